dendrite_drain: RTL and testbench

DENDRITE_DRAIN -- requirements
Module: dendrite_drain

---
 rtl/dendrite_drain_pkg.sv | 17 +
 rtl/dendrite_drain.sv | 138 +++++++++++++
 tb/tb_dendrite_drain.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dendrite_drain_pkg.sv
// Shared network package: default widths and the drain FSM state encoding.
// InputRouter imports the same definitions.
package dendrite_drain_pkg;

    localparam int NEURON_WIDTH_DEF = 11;
    localparam int DATA_WIDTH_DEF   = 44;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_DONE    = 3'd5
    } drain_state_e;

endpackage

// File: rtl/dendrite_drain.sv
// Drains the EX/IN dendritic RAMs once per pass and presents one record per
// local neuron to the neuron unit, optionally zeroing each location afterwards.
module dendrite_drain
    import dendrite_drain_pkg::*;
#(
    parameter int NEURON_WIDTH = NEURON_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           DrainEnable,
    input  logic                           ClearEnable,
    input  logic        [NEURON_WIDTH-1:0] NeuStart,
    input  logic        [NEURON_WIDTH-1:0] NeuEnd,
    input  logic signed [DATA_WIDTH-1:0]   ExWeightSum,
    input  logic signed [DATA_WIDTH-1:0]   InWeightSum,
    output logic                           EXChipEnable,
    output logic                           INChipEnable,
    output logic                           EXWriteEnable,
    output logic                           INWriteEnable,
    output logic        [NEURON_WIDTH-1:0] EXAddress,
    output logic        [NEURON_WIDTH-1:0] INAddress,
    output logic signed [DATA_WIDTH-1:0]   NewExWeightSum,
    output logic signed [DATA_WIDTH-1:0]   NewInWeightSum,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic        [NEURON_WIDTH-1:0] OutNeuronID,
    output logic signed [DATA_WIDTH-1:0]   OutExSum,
    output logic signed [DATA_WIDTH-1:0]   OutInSum,
    output logic                           DrainComplete
);

    drain_state_e                    r_state;
    drain_state_e                    w_next_state;
    logic        [NEURON_WIDTH-1:0]  r_index;
    logic        [NEURON_WIDTH-1:0]  r_start;
    logic        [NEURON_WIDTH-1:0]  r_last;
    logic        [NEURON_WIDTH-1:0]  r_out_id;
    logic signed [DATA_WIDTH-1:0]    r_ex_sum;
    logic signed [DATA_WIDTH-1:0]    r_in_sum;
    logic                            w_read;
    logic                            w_clear_wr;
    logic                            w_access;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; an empty range (end below start) goes straight to DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (DrainEnable) begin
                    if (NeuEnd < NeuStart) w_next_state = ST_DONE;
                    else                   w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ:    w_next_state = ST_WAIT;
            ST_WAIT:    w_next_state = ST_PRESENT;
            ST_PRESENT: begin
                if (OutReady) w_next_state = ST_CLEAR;
                else          w_next_state = ST_PRESENT;
            end
            ST_CLEAR: begin
                if (r_index == r_last) w_next_state = ST_DONE;
                else                   w_next_state = ST_READ;
            end
            ST_DONE: begin
                if (!DrainEnable) w_next_state = ST_IDLE;
                else              w_next_state = ST_DONE;
            end
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Range latch, local index counter and record capture
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_index  <= {NEURON_WIDTH{1'b0}};
            r_start  <= {NEURON_WIDTH{1'b0}};
            r_last   <= {NEURON_WIDTH{1'b0}};
            r_out_id <= {NEURON_WIDTH{1'b0}};
            r_ex_sum <= {DATA_WIDTH{1'b0}};
            r_in_sum <= {DATA_WIDTH{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (DrainEnable) begin
                        r_index <= {NEURON_WIDTH{1'b0}};
                        r_start <= NeuStart;
                        r_last  <= NeuEnd - NeuStart;
                    end
                end
                ST_WAIT: begin
                    r_ex_sum <= ExWeightSum;
                    r_in_sum <= InWeightSum;
                    r_out_id <= r_start + r_index;
                end
                ST_CLEAR: begin
                    if (r_index != r_last) r_index <= r_index + NEURON_WIDTH'(1);
                end
                default: begin
                    r_index <= r_index;
                end
            endcase
        end
    end

    // RAM port decode: reads in READ, zero write-back in CLEAR when enabled
    always_comb begin
        w_read     = (r_state == ST_READ);
        w_clear_wr = (r_state == ST_CLEAR) && ClearEnable;
        w_access   = w_read || w_clear_wr;
    end

    assign EXChipEnable   = w_access;
    assign INChipEnable   = w_access;
    assign EXWriteEnable  = w_clear_wr;
    assign INWriteEnable  = w_clear_wr;
    assign EXAddress      = w_access ? r_index : {NEURON_WIDTH{1'b0}};
    assign INAddress      = w_access ? r_index : {NEURON_WIDTH{1'b0}};
    assign NewExWeightSum = {DATA_WIDTH{1'b0}};
    assign NewInWeightSum = {DATA_WIDTH{1'b0}};
    assign OutValid       = (r_state == ST_PRESENT);
    assign OutNeuronID    = r_out_id;
    assign OutExSum       = r_ex_sum;
    assign OutInSum       = r_in_sum;
    assign DrainComplete  = (r_state == ST_DONE);

endmodule

// File: tb/tb_dendrite_drain.sv
// Scoreboard bench for dendrite_drain: behavioural dendritic RAMs, expected
// records queued at stimulus time, a negedge monitor pops and compares.
module tb_dendrite_drain;

    localparam int NW = 11;
    localparam int DW = 44;

    logic                 Clock = 1'b0;
    logic                 Reset;
    logic                 DrainEnable;
    logic                 ClearEnable;
    logic        [NW-1:0] NeuStart;
    logic        [NW-1:0] NeuEnd;
    logic signed [DW-1:0] ExWeightSum;
    logic signed [DW-1:0] InWeightSum;
    logic                 EXChipEnable, INChipEnable, EXWriteEnable, INWriteEnable;
    logic        [NW-1:0] EXAddress, INAddress;
    logic signed [DW-1:0] NewExWeightSum, NewInWeightSum;
    logic                 OutValid;
    logic                 OutReady = 1'b0;
    logic        [NW-1:0] OutNeuronID;
    logic signed [DW-1:0] OutExSum, OutInSum;
    logic                 DrainComplete;

    typedef struct {
        logic        [NW-1:0] id;
        logic signed [DW-1:0] ex;
        logic signed [DW-1:0] inh;
    } rec_t;

    rec_t sb[$];
    rec_t held;
    logic stall_pend = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ready_mode = 0;
    int valid_seen = 0;
    int we_seen = 0;
    int n_cyc;

    logic signed [DW-1:0] ex_mem [0:2047];
    logic signed [DW-1:0] in_mem [0:2047];
    logic signed [DW-1:0] ex_rd;
    logic signed [DW-1:0] in_rd;

    dendrite_drain #(.NEURON_WIDTH(NW), .DATA_WIDTH(DW)) dut (
        .Clock(Clock), .Reset(Reset), .DrainEnable(DrainEnable), .ClearEnable(ClearEnable),
        .NeuStart(NeuStart), .NeuEnd(NeuEnd),
        .ExWeightSum(ExWeightSum), .InWeightSum(InWeightSum),
        .EXChipEnable(EXChipEnable), .INChipEnable(INChipEnable),
        .EXWriteEnable(EXWriteEnable), .INWriteEnable(INWriteEnable),
        .EXAddress(EXAddress), .INAddress(INAddress),
        .NewExWeightSum(NewExWeightSum), .NewInWeightSum(NewInWeightSum),
        .OutValid(OutValid), .OutReady(OutReady), .OutNeuronID(OutNeuronID),
        .OutExSum(OutExSum), .OutInSum(OutInSum), .DrainComplete(DrainComplete)
    );

    always #5 Clock = ~Clock;

    assign ExWeightSum = ex_rd;
    assign InWeightSum = in_rd;

    // Synchronous RAMs with one-cycle registered read data
    always @(posedge Clock) begin
        if (EXChipEnable) begin
            if (EXWriteEnable) ex_mem[EXAddress] = NewExWeightSum;
            else               ex_rd <= ex_mem[EXAddress];
        end
        if (INChipEnable) begin
            if (INWriteEnable) in_mem[INAddress] = NewInWeightSum;
            else               in_rd <= in_mem[INAddress];
        end
    end

    always @(posedge Clock) cyc <= cyc + 1;

    // Ready pattern: 0 = always ready, 1 = ready one cycle in three
    always @(posedge Clock) begin
        #2;
        case (ready_mode)
            0:       OutReady = 1'b1;
            1:       OutReady = ((cyc % 3) == 0);
            default: OutReady = 1'b0;
        endcase
    end

    function automatic logic signed [DW-1:0] exv(int i);
        logic signed [DW-1:0] v;
        v = DW'(i);
        return v <<< 32;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(int id, logic signed [DW-1:0] e, logic signed [DW-1:0] n);
        rec_t r;
        r.id  = NW'(id);
        r.ex  = e;
        r.inh = n;
        sb.push_back(r);
    endtask

    task automatic init_ram();
        for (int i = 0; i < 2048; i++) begin
            ex_mem[i] = exv(i);
            in_mem[i] = -exv(i);
        end
    endtask

    // Monitor: compares every accepted record and checks stability during stalls
    always @(negedge Clock) begin
        rec_t e;
        if (!Reset) begin
            if (EXWriteEnable || INWriteEnable) we_seen++;
            if (OutValid) begin
                valid_seen++;
                if (stall_pend) begin
                    chk("stall_id", 64'(OutNeuronID), 64'(held.id));
                    chk("stall_ex", 64'(OutExSum), 64'(held.ex));
                    chk("stall_in", 64'(OutInSum), 64'(held.inh));
                end
                if (OutReady) begin
                    stall_pend = 1'b0;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_record: got id %0d expected none", OutNeuronID);
                    end else begin
                        e = sb.pop_front();
                        chk("rec_id", 64'(OutNeuronID), 64'(e.id));
                        chk("rec_ex", 64'(OutExSum), 64'(e.ex));
                        chk("rec_in", 64'(OutInSum), 64'(e.inh));
                    end
                end else begin
                    stall_pend = 1'b1;
                    held.id    = OutNeuronID;
                    held.ex    = OutExSum;
                    held.inh   = OutInSum;
                end
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    task automatic run_pass(int s, int e, logic clr, output int n);
        NeuStart    = NW'(s);
        NeuEnd      = NW'(e);
        ClearEnable = clr;
        @(posedge Clock);
        #1 DrainEnable = 1'b1;
        n = 0;
        do begin
            @(posedge Clock);
            #1 n++;
        end while (!DrainComplete && n < 20000);
        chk("done_reached", 64'(DrainComplete), 64'd1);
        repeat (2) @(posedge Clock);
        #1 chk("done_held", 64'(DrainComplete), 64'd1);
        DrainEnable = 1'b0;
        @(posedge Clock);
        #1 chk("done_release", 64'(DrainComplete), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    function automatic int count_ram_diff(int lo, int hi, bit zero);
        int c = 0;
        for (int i = lo; i <= hi; i++) begin
            if (zero) begin
                if (ex_mem[i] !== '0 || in_mem[i] !== '0) c++;
            end else begin
                if (ex_mem[i] !== exv(i) || in_mem[i] !== -exv(i)) c++;
            end
        end
        return c;
    endfunction

    initial begin
        int k;
        Reset       = 1'b1;
        DrainEnable = 1'b0;
        ClearEnable = 1'b0;
        NeuStart    = '0;
        NeuEnd      = '0;
        init_ram();
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_valid", 64'(OutValid), 64'd0);
        chk("rst_done", 64'(DrainComplete), 64'd0);
        chk("rst_ce", 64'({EXChipEnable, INChipEnable, EXWriteEnable, INWriteEnable}), 64'd0);
        chk("rst_addr", 64'({EXAddress, INAddress}), 64'd0);
        chk("rst_id", 64'(OutNeuronID), 64'd0);
        chk("rst_sums", 64'({OutExSum, OutInSum} != '0), 64'd0);
        Reset = 1'b0;

        // Full pass, always ready, clearing
        for (int i = 0; i < 800; i++) push(784 + i, exv(i), -exv(i));
        run_pass(784, 1583, 1'b1, n_cyc);
        chk("full_cycles", 64'(n_cyc), 64'd3201);
        chk("full_cleared", 64'(count_ram_diff(0, 799, 1'b1)), 64'd0);

        // Same pass with back-pressure
        init_ram();
        ready_mode = 1;
        for (int i = 0; i < 800; i++) push(784 + i, exv(i), -exv(i));
        run_pass(784, 1583, 1'b1, n_cyc);
        ready_mode = 0;
        chk("stall_cleared", 64'(count_ram_diff(0, 799, 1'b1)), 64'd0);

        // No clearing: RAM untouched and no writes
        init_ram();
        we_seen = 0;
        for (int i = 0; i < 800; i++) push(784 + i, exv(i), -exv(i));
        run_pass(784, 1583, 1'b0, n_cyc);
        chk("noclr_we", 64'(we_seen), 64'd0);
        chk("noclr_ram", 64'(count_ram_diff(0, 799, 1'b0)), 64'd0);

        // Single neuron
        ex_mem[0] = 44'sd7;
        in_mem[0] = -44'sd3;
        push(5, 44'sd7, -44'sd3);
        run_pass(5, 5, 1'b1, n_cyc);
        chk("single_cycles", 64'(n_cyc), 64'd5);

        // Empty range
        valid_seen = 0;
        run_pass(5, 4, 1'b1, n_cyc);
        chk("empty_cycles", 64'(n_cyc), 64'd1);
        chk("empty_valid", 64'(valid_seen), 64'd0);

        // Reset while presenting neuron 10
        init_ram();
        for (int i = 0; i < 800; i++) push(784 + i, exv(i), -exv(i));
        NeuStart    = NW'(784);
        NeuEnd      = NW'(1583);
        ClearEnable = 1'b1;
        @(posedge Clock);
        #1 DrainEnable = 1'b1;
        k = 0;
        while (!(OutValid && OutNeuronID == NW'(794)) && k < 10000) begin
            @(posedge Clock);
            #1 k++;
        end
        chk("rst_reach_n10", 64'(OutValid && OutNeuronID == NW'(794)), 64'd1);
        Reset       = 1'b1;
        DrainEnable = 1'b0;
        @(posedge Clock);
        #1;
        chk("abort_valid", 64'(OutValid), 64'd0);
        chk("abort_ce", 64'({EXChipEnable, INChipEnable, EXWriteEnable, INWriteEnable}), 64'd0);
        chk("abort_id", 64'(OutNeuronID), 64'd0);
        chk("abort_pending", 64'(sb.size()), 64'd790);
        chk("abort_low_cleared", 64'(count_ram_diff(0, 9, 1'b1)), 64'd0);
        chk("abort_high_kept", 64'(count_ram_diff(10, 799, 1'b0)), 64'd0);
        sb.delete();
        Reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i < 10) push(784 + i, '0, '0);
            else        push(784 + i, exv(i), -exv(i));
        end
        run_pass(784, 1583, 1'b1, n_cyc);
        chk("restart_cycles", 64'(n_cyc), 64'd3201);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
